// File: rtl/addsub_pkg.sv
// Shared definitions for the add/subtract pipeline: operation encodings.
package addsub_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ACC  = 2'b10,
        OP_LOAD = 2'b11
    } op_t;

endpackage

// File: rtl/addsub_sat_core.sv
// Signed WIDTH-bit add/subtract with one guard bit, overflow detection and
// optional clamping to the most positive / most negative representable value.
module addsub_sat_core #(
    parameter int WIDTH = 32,
    parameter bit SAT   = 1'b1
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    output logic [WIDTH-1:0] value,
    output logic             ovf
);

    // Clamp value for the direction of the overflow (neg = result went below min).
    function automatic logic [WIDTH-1:0] clamp_value(input logic neg);
        logic [WIDTH-1:0] v;
        if (neg) begin
            v = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            v = {1'b0, {(WIDTH-1){1'b1}}};
        end
        return v;
    endfunction

    logic [WIDTH:0] x_ext_s;
    logic [WIDTH:0] y_ext_s;
    logic [WIDTH:0] sum_s;

    // Guard-bit arithmetic: a mismatch between the two top bits means the true
    // result does not fit in WIDTH bits; the guard bit gives the true sign.
    always_comb begin
        x_ext_s = {x[WIDTH-1], x};
        y_ext_s = {y[WIDTH-1], y};
        if (sub) begin
            sum_s = x_ext_s - y_ext_s;
        end else begin
            sum_s = x_ext_s + y_ext_s;
        end
        ovf = sum_s[WIDTH] ^ sum_s[WIDTH-1];
        if (SAT && ovf) begin
            value = clamp_value(sum_s[WIDTH]);
        end else begin
            value = sum_s[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/addsub_pipe.sv
// Two-stage signed add/subtract/accumulate pipeline with valid/ready on both
// sides. Stage 1 computes on accept; stage 2 is the output register.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter bit SAT   = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    op_t              op_s;
    logic [WIDTH-1:0] core_x_s;
    logic [WIDTH-1:0] core_y_s;
    logic             core_sub_s;
    logic [WIDTH-1:0] core_value_s;
    logic             core_ovf_s;
    logic             accept_s;
    logic             s2_load_s;

    logic             s1_valid_r;
    logic [WIDTH-1:0] s1_value_r;
    logic             s1_ovf_r;
    logic             s2_valid_r;
    logic [WIDTH-1:0] s2_value_r;
    logic             s2_ovf_r;
    logic [WIDTH-1:0] acc_r;

    // Stage 1 drains into stage 2 whenever stage 2 is empty or being read out.
    assign s2_load_s = s1_valid_r && (!s2_valid_r || out_ready);
    // No dependence on in_valid, so upstream sees no combinational loop.
    assign in_ready  = !s1_valid_r || !s2_valid_r || out_ready;
    assign accept_s  = in_valid && in_ready;

    // Operand routing: ACC adds a to the accumulator; LOAD passes a through as
    // a+0, which can never overflow, so ovf comes out 0 without a bypass.
    always_comb begin
        op_s       = op_t'(op);
        core_x_s   = a;
        core_y_s   = b;
        core_sub_s = 1'b0;
        case (op_s)
            OP_ADD: begin
                core_x_s = a;
                core_y_s = b;
            end
            OP_SUB: begin
                core_sub_s = 1'b1;
            end
            OP_ACC: begin
                core_x_s = acc_r;
                core_y_s = a;
            end
            OP_LOAD: begin
                core_x_s = a;
                core_y_s = {WIDTH{1'b0}};
            end
            default: begin
                core_x_s = a;
                core_y_s = b;
            end
        endcase
    end

    addsub_sat_core #(
        .WIDTH (WIDTH),
        .SAT   (SAT)
    ) u_core (
        .x     (core_x_s),
        .y     (core_y_s),
        .sub   (core_sub_s),
        .value (core_value_s),
        .ovf   (core_ovf_s)
    );

    // Stage 1 register: captures on accept, empties when drained and not refilled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_r <= 1'b0;
            s1_value_r <= {WIDTH{1'b0}};
            s1_ovf_r   <= 1'b0;
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_value_r <= core_value_s;
            s1_ovf_r   <= core_ovf_s;
        end else if (s2_load_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // Stage 2 (output) register: data only changes on load, so it holds under stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid_r <= 1'b0;
            s2_value_r <= {WIDTH{1'b0}};
            s2_ovf_r   <= 1'b0;
        end else if (s2_load_s) begin
            s2_valid_r <= 1'b1;
            s2_value_r <= s1_value_r;
            s2_ovf_r   <= s1_ovf_r;
        end else if (out_ready) begin
            s2_valid_r <= 1'b0;
        end
    end

    // Accumulator takes the final (clamped or wrapped) value on the accept edge,
    // so the next ACC beat in the following cycle already sees it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_r <= {WIDTH{1'b0}};
        end else if (accept_s && ((op_s == OP_ACC) || (op_s == OP_LOAD))) begin
            acc_r <= core_value_s;
        end
    end

    assign out_valid = s2_valid_r;
    assign result    = s2_value_r;
    assign ovf       = s2_ovf_r;

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe: a saturating and a wrapping instance share
// the same stimulus; a queue-based arithmetic model predicts every output beat.
module tb_addsub_pipe;

    localparam int W = 16;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                in_valid = 1'b0;
    logic [1:0]          op = 2'd0;
    logic signed [W-1:0] a = '0;
    logic signed [W-1:0] b = '0;
    logic                out_ready = 1'b1;

    logic                in_ready_s, out_valid_s, ovf_s;
    logic signed [W-1:0] result_s;
    logic                in_ready_w, out_valid_w, ovf_w;
    logic signed [W-1:0] result_w;

    always #5 clk = ~clk;

    addsub_pipe #(.WIDTH(W), .SAT(1'b1)) dut_s (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .a(a), .b(b), .op(op), .out_valid(out_valid_s), .out_ready(out_ready),
        .result(result_s), .ovf(ovf_s)
    );

    addsub_pipe #(.WIDTH(W), .SAT(1'b0)) dut_w (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .a(a), .b(b), .op(op), .out_valid(out_valid_w), .out_ready(out_ready),
        .result(result_w), .ovf(ovf_w)
    );

    typedef struct {
        int     e;
        longint vs; bit os;
        longint vw; bit ow;
        bit     lit;
        longint ls; bit los;
        longint lw; bit low;
    } item_t;

    item_t  q[$];
    longint acc_s_m = 0, acc_w_m = 0;
    int     n_vec = 0, n_err = 0;
    int     cyc = 0;
    bit     run = 1'b0;
    bit     fired = 1'b0;
    bit     p_lit;
    longint p_ls, p_lw;
    bit     p_los, p_low;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic on unbounded integers, then clamp or wrap to 16 bits.
    function automatic void calc(input logic [1:0] o, input longint av, input longint bv,
                                 input longint acc, input bit sat,
                                 output longint v, output bit ov);
        longint r;
        logic [W-1:0] t;
        case (o)
            2'd0:    r = av + bv;
            2'd1:    r = av - bv;
            2'd2:    r = acc + av;
            default: r = av;
        endcase
        ov = (r > 32767) || (r < -32768);
        if (ov && sat) begin
            v = (r > 0) ? 32767 : -32768;
        end else begin
            t = r[W-1:0];
            v = longint'($signed(t));
        end
    endfunction

    // Per-cycle compare against the model, then advance the model by one edge.
    always @(negedge clk) begin
        bit  exp_ov;
        item_t it;
        if (reset_n && run) begin
            exp_ov = (q.size() > 0) && (cyc >= q[0].e + 2);
            chk("out_valid_sat", out_valid_s, exp_ov);
            chk("out_valid_wrap", out_valid_w, exp_ov);
            chk("in_ready_sat", in_ready_s, (q.size() < 2) || out_ready);
            chk("in_ready_wrap", in_ready_w, (q.size() < 2) || out_ready);
            if (exp_ov) begin
                chk("result_sat", result_s, q[0].vs);
                chk("ovf_sat", ovf_s, q[0].os);
                chk("result_wrap", result_w, q[0].vw);
                chk("ovf_wrap", ovf_w, q[0].ow);
                if (q[0].lit) begin
                    chk("lit_result_sat", result_s, q[0].ls);
                    chk("lit_ovf_sat", ovf_s, q[0].los);
                    chk("lit_result_wrap", result_w, q[0].lw);
                    chk("lit_ovf_wrap", ovf_w, q[0].low);
                end
                if (out_ready) void'(q.pop_front());
            end
            fired = in_valid && in_ready_s;
            if (fired) begin
                it.e = cyc;
                calc(op, longint'(a), longint'(b), acc_s_m, 1'b1, it.vs, it.os);
                calc(op, longint'(a), longint'(b), acc_w_m, 1'b0, it.vw, it.ow);
                if (op[1]) begin
                    acc_s_m = it.vs;
                    acc_w_m = it.vw;
                end
                it.lit = p_lit; it.ls = p_ls; it.los = p_los; it.lw = p_lw; it.low = p_low;
                q.push_back(it);
            end
        end else begin
            fired = 1'b0;
        end
        cyc++;
    end

    // Present one beat and hold it until accepted (bounded wait).
    task automatic beat(input logic [1:0] o, input int av, input int bv, input bit has_lit,
                        input int ls, input bit los, input int lw, input bit low);
        bit ok;
        p_lit = has_lit; p_ls = ls; p_los = los; p_lw = lw; p_low = low;
        op = o; a = av[W-1:0]; b = bv[W-1:0]; in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            if (fired) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        in_valid = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk("reset_result_sat", result_s, 0);
        chk("reset_ovf_sat", ovf_s, 0);
        chk("reset_result_wrap", result_w, 0);
        chk("reset_out_valid", out_valid_s, 0);
        chk("reset_in_ready", in_ready_s, 1);
        @(posedge clk); #1;
        run = 1'b1;

        // Basic add/sub, then both overflow directions.
        beat(2'd0, 100, -30, 1'b1, 70, 1'b0, 70, 1'b0);
        beat(2'd1, 5, 7, 1'b1, -2, 1'b0, -2, 1'b0);
        beat(2'd0, 32767, 1, 1'b1, 32767, 1'b1, -32768, 1'b1);
        beat(2'd1, -32768, 1, 1'b1, -32768, 1'b1, 32767, 1'b1);
        idle(3);

        // Back-to-back accumulate chain.
        beat(2'd3, 10, 999, 1'b1, 10, 1'b0, 10, 1'b0);
        beat(2'd2, 5, 999, 1'b1, 15, 1'b0, 15, 1'b0);
        beat(2'd2, 5, 999, 1'b1, 20, 1'b0, 20, 1'b0);
        beat(2'd2, -25, 999, 1'b1, -5, 1'b0, -5, 1'b0);
        idle(4);

        // Six beats against a 4-cycle downstream stall.
        out_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 6; i++)
                    beat(2'd0, 1000 * i, i, 1'b1, 1001 * i, 1'b0, 1001 * i, 1'b0);
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        idle(4);

        // Saturating accumulator keeps the clamped value.
        beat(2'd3, 20000, 0, 1'b1, 20000, 1'b0, 20000, 1'b0);
        beat(2'd2, 20000, 0, 1'b1, 32767, 1'b1, -25536, 1'b1);
        beat(2'd2, 20000, 0, 1'b1, 32767, 1'b1, -5536, 1'b0);
        beat(2'd2, -1, 0, 1'b1, 32766, 1'b0, -5537, 1'b0);
        idle(4);

        // Asynchronous reset with two beats in flight and acc=123.
        beat(2'd3, 123, 0, 1'b1, 123, 1'b0, 123, 1'b0);
        idle(3);
        out_ready = 1'b0;
        beat(2'd0, 1, 1, 1'b1, 2, 1'b0, 2, 1'b0);
        beat(2'd0, 2, 2, 1'b1, 4, 1'b0, 4, 1'b0);
        @(posedge clk);
        #2 reset_n = 1'b0;
        q.delete();
        acc_s_m = 0;
        acc_w_m = 0;
        #1;
        chk("midreset_out_valid_sat", out_valid_s, 0);
        chk("midreset_out_valid_wrap", out_valid_w, 0);
        chk("midreset_result_sat", result_s, 0);
        chk("midreset_result_wrap", result_w, 0);
        #1 reset_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        beat(2'd2, 7, 0, 1'b1, 7, 1'b0, 7, 1'b0);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        idle(2);
        chk("drain_empty", q.size(), 0);
        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
